mtr_drv: RTL and testbench
==========================

// Module: mtr_drv
// PURPOSE
//  Consumer of the signed left/right speed words produced by the segway math block.
//  Converts each speed into complementary 11-bit PWM pairs with non-overlap dead time for two H-bridges.
//  Monitors the bridge over-current comparators with blanking and latches a shutdown on persistent faults.
//  Sits between the math block and the motor-driver pins.
// PARAMETERS
//  NONOVERLAP  11'h020  dead time in clk cycles between one side of a bridge falling and the other rising
//  BLANK       8'd128   clk cycles after any PWM rising edge during which OVR_I is ignored
//  MAX_OVR     4'd8     consecutive faulted PWM periods that trigger shutdown
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous active-low reset
//  lft_spd       in   12  signed left speed; -2048..2047
//  rght_spd      in   12  signed right speed; -2048..2047
//  OVR_I_lft     in   1   left bridge over-current comparator; asynchronous
//  OVR_I_rght    in   1   right bridge over-current comparator; asynchronous
//  PWM1_lft      out  1   left forward gate drive; registered
//  PWM2_lft      out  1   left reverse gate drive; registered
//  PWM1_rght     out  1   right forward gate drive; registered
//  PWM2_rght     out  1   right reverse gate drive; registered
//  PWM_synch     out  1   one-clk pulse when cnt==0; marks the PWM period start
//  OVR_I_shtdwn  out  1   latched fault; forces all PWM outputs low
// BEHAVIOUR
//  Interface: one clock, clk; reset rst_n is asynchronous, active-low. All outputs and state are 0 at reset, except:
//   - duty registers reset to 11'h400.
//  cnt: free-running 11-bit counter; 0..2047, wraps 2047->0.
//  Duty per side: duty_nxt = (spd>>>1)[10:0] + 11'h400 (mod 2^11).
//   - This gives -2048->0, 0->1024, 2047->2047.
//   - Duty is captured into the duty register only on the clk edge where cnt==2047, so it is stable within a period.
//  PWM1 per side:
//   - Sets on the edge where cnt==NONOVERLAP.
//   - Clears on any edge where cnt>=duty. Clear has priority over set.
//  PWM2 per side:
//   - Sets on the edge where {1'b0,cnt}=={1'b0,duty}+NONOVERLAP (12-bit compare; never sets if the sum >2047).
//   - Clears on the edge where cnt==0.
//  Outputs are flop Qs; there are never both PWM1 and PWM2 of one side high in the same cycle.
//  Gap between PWM1 falling and PWM2 rising >= NONOVERLAP clks.
//  Gap between PWM2 falling and PWM1 rising == NONOVERLAP clks.
//  OVR_I inputs: double-flop synchronised before any use.
//  Blank counter per side (8 bit):
//   - Cleared to 0 on the cycle after a rising edge of that side's PWM1 or PWM2.
//   - Otherwise increments, saturating at BLANK.
//  Fault flag per side: set when synced OVR_I==1 && blank counter==BLANK && (PWM1|PWM2).
//  At the cnt==2047 edge:
//   - Fault flags clear.
//   - If either flag is set (including a set in that same cycle): ovr_cnt++. Otherwise ovr_cnt=0.
//   - When ovr_cnt reaches MAX_OVR, OVR_I_shtdwn sets.
//  OVR_I_shtdwn clears only on rst_n.
//  Once OVR_I_shtdwn is set:
//   - All four PWM flops are held clear from the next edge on.
//   - cnt and PWM_synch keep running.
//  Reset mid-period: all outputs drop asynchronously; after release, restart from cnt=0 with duty 11'h400.
// TESTING
//  1. lft_spd=rght_spd=0, 4 periods -> each PWM1 high 992 clks (cnt 33..1024), PWM2 high 992 clks (cnt 1057..0); gaps 32 clks; PWM_synch every 2048 clks.
//  2. lft_spd=12'h7FF, rght_spd=12'h800 -> PWM1_lft high cnt 33..2047, PWM2_lft never; PWM1_rght never, PWM2_rght high cnt 33..0 (2016 clks).
//  3. Change lft_spd from 0 to 12'h200 at cnt==500 -> current period unchanged; next period PWM1_lft clears at cnt==1280.
//  4. OVR_I_lft pulsed for 100 clks right after each PWM rising edge (inside blank) -> no fault, OVR_I_shtdwn stays 0.
//  5. OVR_I_lft held 1, spd=0 -> OVR_I_shtdwn rises at the end of the 8th period; all PWM low thereafter; a clean period does not clear it.
//  6. rst_n asserted at cnt==700 with PWM1_lft high -> all outputs 0 immediately; after release PWM1 first rises on the edge at cnt==32.

Source files
------------

// File: rtl/mtr_drv.sv
// Dual H-bridge PWM driver: turns the signed left/right speed words into
// complementary 11-bit PWM pairs with dead time. It also watches the bridge
// over-current comparators, ignoring them during a blanking window, and
// latches a shutdown after repeated faulted periods.
module mtr_drv #(
  parameter logic [10:0] NONOVERLAP = 11'h020,
  parameter logic [7:0]  BLANK      = 8'd128,
  parameter logic [3:0]  MAX_OVR    = 4'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        OVR_I_lft,
  input  logic        OVR_I_rght,
  output logic        PWM1_lft,
  output logic        PWM2_lft,
  output logic        PWM1_rght,
  output logic        PWM2_rght,
  output logic        PWM_synch,
  output logic        OVR_I_shtdwn
);

  localparam logic [10:0] CNT_LAST = 11'h7FF;
  localparam logic [10:0] DUTY_MID = 11'h400;

  logic [10:0]      cnt;
  logic             period_end;
  logic [1:0][11:0] spd;
  logic [1:0]       ovr_in;
  logic [1:0]       pwm1;
  logic [1:0]       pwm2;
  logic [1:0]       fault_hit;
  logic [1:0]       fault_flag;
  logic [3:0]       ovr_cnt;
  logic [3:0]       ovr_cnt_inc;
  logic             any_fault;

  // Index 0 is the left bridge, index 1 is the right bridge.
  assign spd        = {rght_spd, lft_spd};
  assign ovr_in     = {OVR_I_rght, OVR_I_lft};
  assign period_end = (cnt == CNT_LAST);

  // Free-running period counter; PWM_synch is registered, so it is high
  // in the cycle where cnt reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state always uses non-blocking assignments, so every
    // flop samples the values from before the edge and the order of the
    // statements cannot change the result.
    if (!rst_n) begin
      cnt       <= '0;
      PWM_synch <= 1'b0;
    end else begin
      cnt       <= cnt + 11'd1;
      PWM_synch <= period_end;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_side
    logic [10:0] duty;
    logic [10:0] duty_nxt;
    logic [11:0] pwm2_on;
    logic        p1;
    logic        p2;
    logic        p1_d;
    logic        p2_d;
    logic        rise;
    logic [1:0]  ovr_sync;
    logic [7:0]  blank;
    logic        flag;

    // Halve the speed and offset it to mid-scale: -2048 -> 0, 0 -> 1024, 2047 -> 2047.
    assign duty_nxt = 11'($signed(spd[g]) >>> 1) + DUTY_MID;
    // PWM2 turn-on point. The extra bit stops a sum above 2047 from wrapping
    // around to an early match.
    assign pwm2_on  = {1'b0, duty} + {1'b0, NONOVERLAP};
    assign rise     = (p1 & ~p1_d) | (p2 & ~p2_d);

    // Load the duty only at the period boundary, so it stays constant for a whole period.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          duty <= DUTY_MID;
      else if (period_end) duty <= duty_nxt;
    end

    // Gate flops. A clear wins over a set, and a latched shutdown holds both gates low.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p1   <= 1'b0;
        p2   <= 1'b0;
        p1_d <= 1'b0;
        p2_d <= 1'b0;
      end else begin
        p1_d <= p1;
        p2_d <= p2;
        if (OVR_I_shtdwn) begin
          p1 <= 1'b0;
          p2 <= 1'b0;
        end else begin
          if (cnt >= duty)              p1 <= 1'b0;
          else if (cnt == NONOVERLAP)   p1 <= 1'b1;
          if (cnt == '0)                p2 <= 1'b0;
          else if ({1'b0, cnt} == pwm2_on) p2 <= 1'b1;
        end
      end
    end

    // Synchronise the comparator and time the blanking window after each gate rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ovr_sync <= '0;
        blank    <= '0;
      end else begin
        ovr_sync <= {ovr_sync[0], ovr_in[g]};
        if (rise)                blank <= '0;
        else if (blank != BLANK) blank <= blank + 8'd1;
      end
    end

    assign fault_hit[g] = ovr_sync[1] & (blank == BLANK) & (p1 | p2);

    // Per-period fault flag; it is cleared at the period boundary after the period has been scored.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            flag <= 1'b0;
      else if (period_end)   flag <= 1'b0;
      else if (fault_hit[g]) flag <= 1'b1;
    end

    assign pwm1[g]       = p1;
    assign pwm2[g]       = p2;
    assign fault_flag[g] = flag;
  end

  // A fault detected in the last cycle of the period still counts toward that period.
  assign any_fault   = (|fault_flag) | (|fault_hit);
  assign ovr_cnt_inc = (ovr_cnt == MAX_OVR) ? ovr_cnt : ovr_cnt + 4'd1;

  // Count consecutive faulted periods; the shutdown latch is cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt      <= '0;
      OVR_I_shtdwn <= 1'b0;
    end else if (period_end) begin
      if (any_fault) begin
        ovr_cnt <= ovr_cnt_inc;
        if (ovr_cnt_inc == MAX_OVR) OVR_I_shtdwn <= 1'b1;
      end else begin
        ovr_cnt <= '0;
      end
    end
  end

  assign PWM1_lft  = pwm1[0];
  assign PWM2_lft  = pwm2[0];
  assign PWM1_rght = pwm1[1];
  assign PWM2_rght = pwm2[1];

endmodule

// File: tb/tb_mtr_drv.sv
// Bench for mtr_drv. A reference model works out each cycle's expected outputs
// from the period position and duty with plain interval arithmetic. Every cycle
// the DUT outputs are compared with that model. Hand-computed literal checks at
// chosen counter values also test the model itself.
module tb_mtr_drv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] lft_spd = '0;
  logic [11:0] rght_spd = '0;
  logic        OVR_I_lft = 1'b0;
  logic        OVR_I_rght = 1'b0;
  logic        PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght, PWM_synch, OVR_I_shtdwn;

  always #5 clk = ~clk;

  mtr_drv dut (
    .clk(clk), .rst_n(rst_n), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .OVR_I_lft(OVR_I_lft), .OVR_I_rght(OVR_I_rght),
    .PWM1_lft(PWM1_lft), .PWM2_lft(PWM2_lft), .PWM1_rght(PWM1_rght),
    .PWM2_rght(PWM2_rght), .PWM_synch(PWM_synch), .OVR_I_shtdwn(OVR_I_shtdwn)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // m_c is the counter value in the current cycle. m_age counts the cycles since
  // the latest gate rising edge; the blanking window has expired once m_age is at least 129.
  int  m_c;
  int  m_duty[2];
  int  m_duty_prev[2];
  bit  m_prev_valid, m_first;
  bit  m_sh, m_sh_last;
  int  m_age[2];
  bit  m_p1_last[2], m_p2_last[2];
  bit  m_r1[2], m_r2[2];
  bit  m_any;
  int  m_ovr_cnt;
  bit  e_p1[2], e_p2[2];
  bit  e_sy, e_sh;

  function automatic int duty_of(input logic [11:0] s);
    int v;
    v = int'($signed(s));
    return ((v >>> 1) + 1024) & 2047;
  endfunction

  task automatic model_reset();
    m_c = 0; m_prev_valid = 0; m_first = 1; m_sh = 0; m_sh_last = 0;
    m_any = 0; m_ovr_cnt = 0;
    for (int s = 0; s < 2; s++) begin
      m_duty[s] = 1024; m_duty_prev[s] = 1024; m_age[s] = 1;
      m_p1_last[s] = 0; m_p2_last[s] = 0; m_r1[s] = 0; m_r2[s] = 0;
    end
  endtask

  task automatic model_expect();
    for (int s = 0; s < 2; s++) begin
      // PWM1 is high for counts NONOVERLAP+1 .. duty.
      e_p1[s] = !m_sh_last && (m_c >= 33) && (m_c <= m_duty[s]);
      // PWM2 is high from duty+NONOVERLAP+1 to the end of the period. It is also high
      // at count 0 if it was high at the end of the previous period.
      if (m_c == 0) e_p2[s] = !m_sh_last && m_prev_valid && (m_duty_prev[s] <= 2015);
      else          e_p2[s] = !m_sh_last && (m_c >= m_duty[s] + 33);
    end
    e_sy = (m_c == 0) && !m_first;
    e_sh = m_sh;
  endtask

  task automatic model_advance();
    bit raw[2];
    bit rise;
    raw[0] = OVR_I_lft;
    raw[1] = OVR_I_rght;
    for (int s = 0; s < 2; s++) begin
      if (m_r2[s] && m_age[s] >= 129 && (e_p1[s] || e_p2[s])) m_any = 1;
      rise = (e_p1[s] && !m_p1_last[s]) || (e_p2[s] && !m_p2_last[s]);
      if (rise) m_age[s] = 1;
      else if (m_age[s] < 100000) m_age[s]++;
      m_p1_last[s] = e_p1[s];
      m_p2_last[s] = e_p2[s];
      m_r2[s] = m_r1[s];
      m_r1[s] = raw[s];
    end
    m_sh_last = m_sh;
    if (m_c == 2047) begin
      if (m_any) begin
        m_ovr_cnt++;
        if (m_ovr_cnt >= 8) m_sh = 1;
      end else begin
        m_ovr_cnt = 0;
      end
      m_any = 0;
      m_duty_prev = m_duty;
      m_duty[0] = duty_of(lft_spd);
      m_duty[1] = duty_of(rght_spd);
      m_prev_valid = 1;
    end
    m_first = 0;
    m_c = (m_c + 1) % 2048;
  endtask

  // Per-cycle compare on the falling edge. The model then steps to the state after the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    else begin
      model_expect();
      check("pwm1_lft",  PWM1_lft,     e_p1[0]);
      check("pwm2_lft",  PWM2_lft,     e_p2[0]);
      check("pwm1_rght", PWM1_rght,    e_p1[1]);
      check("pwm2_rght", PWM2_rght,    e_p2[1]);
      check("pwm_synch", PWM_synch,    e_sy);
      check("shtdwn",    OVR_I_shtdwn, e_sh);
      model_advance();
    end
  end

  // ---------------- stimulus ----------------
  int ovr_mode = 0;
  bit noise_on = 0;

  task automatic drive_ovr();
    case (ovr_mode)
      1: begin
        OVR_I_lft  = (m_age[0] <= 100);
        OVR_I_rght = (m_age[1] <= 60) && ($urandom_range(0, 1) == 1);
      end
      2: begin
        OVR_I_lft  = noise_on && ($urandom_range(0, 199) == 0);
        OVR_I_rght = noise_on && ($urandom_range(0, 199) == 0);
      end
      3: begin
        OVR_I_lft  = 1'b1;
        OVR_I_rght = 1'b0;
      end
      default: begin
        OVR_I_lft  = 1'b0;
        OVR_I_rght = 1'b0;
      end
    endcase
  endtask

  // Step one clock at a time, 1 time unit after each rising edge, until the count reaches v.
  task automatic wait_c(input int v);
    for (int i = 0; i < 4200; i++) begin
      @(posedge clk);
      #1;
      drive_ovr();
      if (m_c == v) return;
    end
    n_checks++;
    $display("FAIL wait_c: count %0d not reached within 4200 cycles", v);
  endtask

  function automatic logic [11:0] rand_spd();
    case ($urandom_range(0, 3))
      0:       return 12'h800;
      1:       return 12'h7FF;
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic outputs_low(input string tag);
    check({tag, "_pwm1_lft"},  PWM1_lft,     1'b0);
    check({tag, "_pwm2_lft"},  PWM2_lft,     1'b0);
    check({tag, "_pwm1_rght"}, PWM1_rght,    1'b0);
    check({tag, "_pwm2_rght"}, PWM2_rght,    1'b0);
    check({tag, "_synch"},     PWM_synch,    1'b0);
    check({tag, "_shtdwn"},    OVR_I_shtdwn, 1'b0);
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    #1;
    outputs_low("rst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    outputs_low("init");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Zero speed: duty 1024, 32-cycle gaps.
    wait_c(32);   check("z_p1_c32", PWM1_lft, 1'b0);
    wait_c(33);   check("z_p1_c33", PWM1_lft, 1'b1); check("z_p1r_c33", PWM1_rght, 1'b1);
    wait_c(1024); check("z_p1_c1024", PWM1_lft, 1'b1);
    wait_c(1025); check("z_p1_c1025", PWM1_lft, 1'b0);
    wait_c(1056); check("z_p2_c1056", PWM2_lft, 1'b0);
    wait_c(1057); check("z_p2_c1057", PWM2_lft, 1'b1);
    wait_c(0);    check("z_p2_c0", PWM2_lft, 1'b1); check("z_synch_c0", PWM_synch, 1'b1);
    wait_c(1);    check("z_p2_c1", PWM2_lft, 1'b0); check("z_synch_c1", PWM_synch, 1'b0);
    wait_c(0);
    wait_c(0);

    // Full forward on the left, full reverse on the right; the new duty applies from the next period.
    wait_c(1);
    lft_spd = 12'h7FF; rght_spd = 12'h800;
    wait_c(0);
    wait_c(32);   check("x_p2r_c32", PWM2_rght, 1'b0); check("x_p1r_c32", PWM1_rght, 1'b0);
    wait_c(33);   check("x_p2r_c33", PWM2_rght, 1'b1); check("x_p1l_c33", PWM1_lft, 1'b1);
    wait_c(1500); check("x_p1r_c1500", PWM1_rght, 1'b0); check("x_p2l_c1500", PWM2_lft, 1'b0);
    wait_c(2047); check("x_p1l_c2047", PWM1_lft, 1'b1); check("x_p2r_c2047", PWM2_rght, 1'b1);
    lft_spd = 12'h000; rght_spd = 12'h000;
    wait_c(0);    check("x_p1l_c0", PWM1_lft, 1'b0); check("x_p2l_c0", PWM2_lft, 1'b0);
                  check("x_p2r_c0", PWM2_rght, 1'b1);

    // A speed change in mid-period does not affect the current period.
    wait_c(500);  lft_spd = 12'h200;
    wait_c(1024); check("m_p1_c1024", PWM1_lft, 1'b1);
    wait_c(1025); check("m_p1_c1025", PWM1_lft, 1'b0);
    wait_c(0);
    wait_c(1280); check("m_p1_c1280", PWM1_lft, 1'b1);
    wait_c(1281); check("m_p1_c1281", PWM1_lft, 1'b0);

    // Over-current pulses only inside the blanking window, with random speeds.
    ovr_mode = 1;
    for (int p = 0; p < 3; p++) begin
      wait_c($urandom_range(1, 2046));
      lft_spd = rand_spd(); rght_spd = rand_spd();
      wait_c(0);
    end
    wait_c(10);
    check("blank_no_shtdwn", OVR_I_shtdwn, 1'b0);

    // Random sparse over-current noise, switched on or off for each period.
    ovr_mode = 2;
    for (int p = 0; p < 3; p++) begin
      noise_on = ($urandom_range(0, 1) == 1);
      wait_c($urandom_range(1, 2046));
      lft_spd = rand_spd(); rght_spd = rand_spd();
      wait_c(0);
    end

    // Persistent over-current: the shutdown latches after the 8th faulted period.
    ovr_mode = 0;
    lft_spd = '0; rght_spd = '0;
    @(posedge clk);
    #1;
    hold_reset();
    ovr_mode = 3;
    for (int p = 0; p < 8; p++) wait_c(2047);
    check("sd_before", OVR_I_shtdwn, 1'b0);
    wait_c(0);    check("sd_set", OVR_I_shtdwn, 1'b1); check("sd_synch", PWM_synch, 1'b1);
    wait_c(33);   check("sd_p1l", PWM1_lft, 1'b0); check("sd_p1r", PWM1_rght, 1'b0);
    wait_c(1100); check("sd_p2l", PWM2_lft, 1'b0); check("sd_p2r", PWM2_rght, 1'b0);
    ovr_mode = 0;
    wait_c(0);
    wait_c(2047);
    wait_c(0);    check("sd_sticky", OVR_I_shtdwn, 1'b1);

    // Reset in mid-period: outputs drop at once, then the period restarts from count 0.
    hold_reset();
    wait_c(700);  check("r_p1_c700", PWM1_lft, 1'b1);
    hold_reset();
    wait_c(32);   check("r_p1_c32", PWM1_lft, 1'b0);
    wait_c(33);   check("r_p1_c33", PWM1_lft, 1'b1);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
